// File: rtl/lexington.sv
`default_nettype none
// ============================================================================
// Package  : lexington
// Purpose  : Fetch-stage FSM states, the NOP encoding and the buffer entry.
// Revision : 1.0 - initial release
// ============================================================================
package lexington;

   // IDLE: no request; REQ: request outstanding, data kept;
   // FLUSH: request outstanding, data discarded on ack
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   // addi x0, x0, 0
   localparam rv32::word c_nop_inst = 32'h0000_0013;

   typedef struct packed {
      rv32::word inst;
      rv32::word pc;
      logic      misaligned;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv32.sv
`default_nettype none
// ============================================================================
// Package  : rv32
// Purpose  : Basic RV32 data types shared across the fetch slice.
// Revision : 1.0 - initial release
// ============================================================================
package rv32;

   typedef logic [31:0] word;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Purpose  : 2-entry in-order instruction buffer with push/pop/flush/count.
//            A flush empties the buffer but may accept one entry in the same
//            cycle, which lands in slot 0 as the new head.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buf
   import lexington::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  rv32::word  push_inst,
   input  rv32::word  push_pc,
   input  logic       push_mis,
   input  logic       pop,
   output rv32::word  head_inst,
   output rv32::word  head_pc,
   output logic       head_mis,
   output logic [1:0] count
);

   fetch_entry_t r_mem [2];
   fetch_entry_t w_push_entry;
   fetch_entry_t w_head;
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   assign w_push_entry = '{inst: push_inst, pc: push_pc, misaligned: push_mis};

   // Storage, pointers and occupancy; the controller never pushes when full
   // nor pops when empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= push;
         r_count  <= {1'b0, push};
         if (push) begin
            r_mem[0] <= w_push_entry;
         end
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign head_inst = w_head.inst;
   assign head_pc   = w_head.pc;
   assign head_mis  = w_head.misaligned;
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction fetch controller: single-outstanding bus requests,
//            2-entry instruction buffer, trap/mret/branch redirects.
// Config   : FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a
//            non-word-aligned target is not fetched; a NOP marker entry with
//            fetch_misaligned=1 is presented and fetching halts until the
//            next redirect. When undefined, target[1:0] is forced to 2'b00.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
   import lexington::*;
#(
   parameter rv32::word RESET_ADDR = 32'h0000_0000
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      stall,
   input  logic      branch_taken,
   input  rv32::word branch_target,
   input  logic      trap_req,
   input  rv32::word trap_vector,
   input  logic      mret_req,
   input  rv32::word mepc,
   output logic      ibus_req,
   output rv32::word ibus_addr,
   input  logic      ibus_ack,
   input  rv32::word ibus_rdata,
   output logic      inst_valid,
   output rv32::word inst,
   output rv32::word inst_pc,
   output rv32::word pc,
   output logic      fetch_misaligned
);

   fetch_state_t r_state;
   rv32::word    r_pc;
   rv32::word    r_addr;
   logic         r_req;
   logic         r_halt;

   rv32::word    w_target_raw;
   rv32::word    w_target;
   rv32::word    w_pc_inc;
   logic         w_redirect;
   logic         w_misaligned;
   logic         w_pop;
   logic         w_keep;
   logic         w_push;
   logic         w_space;
   logic [1:0]   w_count;
   logic [1:0]   w_count_next;
   rv32::word    w_push_inst;
   rv32::word    w_push_pc;
   rv32::word    w_head_inst;
   rv32::word    w_head_pc;
   logic         w_head_mis;

   assign w_redirect = trap_req | mret_req | branch_taken;

   // Redirect target selection: trap > mret > branch
   always_comb begin
      w_target_raw = branch_target;
      if (trap_req) begin
         w_target_raw = trap_vector;
      end else if (mret_req) begin
         w_target_raw = mepc;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_target     = w_target_raw;
   assign w_misaligned = w_redirect & (w_target_raw[1:0] != 2'b00);
`else
   assign w_target     = w_target_raw & 32'hFFFF_FFFC;
   assign w_misaligned = 1'b0;
`endif

   assign w_pc_inc     = r_pc + 32'd4;
   assign w_pop        = inst_valid & ~stall;
   // Ack data is kept only in REQ and only when no redirect discards it
   assign w_keep       = (r_state == REQ) & ibus_ack & ~w_redirect;
   // A misaligned redirect replaces the buffer contents with the marker entry
   assign w_push       = w_keep | w_misaligned;
   assign w_push_inst  = w_misaligned ? c_nop_inst : ibus_rdata;
   assign w_push_pc    = w_misaligned ? w_target : r_pc;
   // Occupancy after this cycle's push and pop; one outstanding request at a
   // time guarantees room for its data when issued below 2
   assign w_count_next = w_count + {1'b0, w_keep} - {1'b0, w_pop};
   assign w_space      = (w_count_next < 2'd2);

   // Fetch FSM; redirects override the normal request/ack flow regardless of stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_ADDR;
         r_addr  <= RESET_ADDR;
         r_req   <= 1'b0;
         r_halt  <= 1'b0;
      end else if (w_redirect) begin
         r_pc   <= w_target;
         r_halt <= w_misaligned;
         if (r_req && !ibus_ack) begin
            r_state <= FLUSH;
         end else begin
            r_state <= IDLE;
            r_req   <= 1'b0;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (w_space && !r_halt) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
               end
            end
            REQ: begin
               if (ibus_ack) begin
                  r_pc <= w_pc_inc;
                  if (w_space) begin
                     r_addr <= w_pc_inc;
                  end else begin
                     r_state <= IDLE;
                     r_req   <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               if (ibus_ack) begin
                  r_state <= IDLE;
                  r_req   <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   fetch_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (w_redirect),
      .push      (w_push),
      .push_inst (w_push_inst),
      .push_pc   (w_push_pc),
      .push_mis  (w_misaligned),
      .pop       (w_pop),
      .head_inst (w_head_inst),
      .head_pc   (w_head_pc),
      .head_mis  (w_head_mis),
      .count     (w_count)
   );

   assign ibus_req         = r_req;
   assign ibus_addr        = r_addr;
   assign pc               = r_pc;
   assign inst_valid       = (w_count != 2'd0);
   assign inst             = w_head_inst;
   assign inst_pc          = w_head_pc;
   // Slot contents may be stale once empty, so the marker flag follows valid
   assign fetch_misaligned = w_head_mis & inst_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl. The bus returns
//            rdata = addr + 0x1000_0000 and acks only while ack_en is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        trap_req;
   logic [31:0] trap_vector;
   logic        mret_req;
   logic [31:0] mepc;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ack;
   logic [31:0] ibus_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] pc;
   logic        fetch_misaligned;
   logic        ack_en;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign ibus_ack   = ack_en & ibus_req;
   assign ibus_rdata = ibus_addr + 32'h1000_0000;

   fetch_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .trap_req         (trap_req),
      .trap_vector      (trap_vector),
      .mret_req         (mret_req),
      .mepc             (mepc),
      .ibus_req         (ibus_req),
      .ibus_addr        (ibus_addr),
      .ibus_ack         (ibus_ack),
      .ibus_rdata       (ibus_rdata),
      .inst_valid       (inst_valid),
      .inst             (inst),
      .inst_pc          (inst_pc),
      .pc               (pc),
      .fetch_misaligned (fetch_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; ack_en = 1'b0;
      branch_taken = 1'b0; branch_target = '0;
      trap_req = 1'b0; trap_vector = '0;
      mret_req = 1'b0; mepc = '0;

      // reset state
      repeat (3) tick();
      chk("rst_req",   {31'd0, ibus_req},         32'd0);
      chk("rst_valid", {31'd0, inst_valid},       32'd0);
      chk("rst_inst",  inst,                      32'd0);
      chk("rst_ipc",   inst_pc,                   32'd0);
      chk("rst_pc",    pc,                        32'd0);
      chk("rst_mis",   {31'd0, fetch_misaligned}, 32'd0);

      // streaming fetch with an ack every cycle
      rst_n = 1'b1; ack_en = 1'b1;
      tick(); // c1
      chk("c1_req",   {31'd0, ibus_req},   32'd1);
      chk("c1_addr",  ibus_addr,           32'h0);
      chk("c1_valid", {31'd0, inst_valid}, 32'd0);
      tick(); // c2
      chk("c2_addr",  ibus_addr,           32'h4);
      chk("c2_valid", {31'd0, inst_valid}, 32'd1);
      chk("c2_ipc",   inst_pc,             32'h0);
      chk("c2_inst",  inst,                32'h1000_0000);
      tick(); // c3
      chk("c3_addr",  ibus_addr,           32'h8);
      chk("c3_ipc",   inst_pc,             32'h4);
      tick(); // c4
      chk("c4_ipc",   inst_pc,             32'h8);
      chk("c4_addr",  ibus_addr,           32'hC);

      // stall held 5 edges: buffer fills to 2 and requests stop
      stall = 1'b1;
      tick(); // c5
      chk("c5_req",   {31'd0, ibus_req},   32'd0);
      chk("c5_ipc",   inst_pc,             32'h8);
      chk("c5_pc",    pc,                  32'h10);
      repeat (3) tick(); // c8
      chk("c8_req",   {31'd0, ibus_req},   32'd0);
      chk("c8_ipc",   inst_pc,             32'h8);
      chk("c8_inst",  inst,                32'h1000_0008);
      tick(); // c9
      stall = 1'b0; ack_en = 1'b0;
      tick(); // c10
      chk("c10_ipc",  inst_pc,             32'hC);
      chk("c10_req",  {31'd0, ibus_req},   32'd1);
      chk("c10_addr", ibus_addr,           32'h10);
      tick(); // c11
      chk("c11_valid", {31'd0, inst_valid}, 32'd0);
      chk("c11_addr",  ibus_addr,           32'h10);
      tick(); // c12
      chk("c12_addr",  ibus_addr,           32'h10);

      // branch while the request to 0x10 waits
      branch_taken = 1'b1; branch_target = 32'h100;
      tick(); // c13
      branch_taken = 1'b0;
      chk("c13_req",  {31'd0, ibus_req},   32'd1);
      chk("c13_addr", ibus_addr,           32'h10);
      chk("c13_pc",   pc,                  32'h100);
      ack_en = 1'b1;
      tick(); // c14
      chk("c14_req",   {31'd0, ibus_req},   32'd0);
      chk("c14_valid", {31'd0, inst_valid}, 32'd0);
      tick(); // c15
      chk("c15_addr",  ibus_addr,           32'h100);
      chk("c15_valid", {31'd0, inst_valid}, 32'd0);
      tick(); // c16
      chk("c16_ipc",   inst_pc,             32'h100);
      chk("c16_inst",  inst,                32'h1000_0100);

      // trap beats branch
      trap_req = 1'b1; trap_vector = 32'h200;
      branch_taken = 1'b1; branch_target = 32'h300;
      tick(); // c17
      trap_req = 1'b0; branch_taken = 1'b0;
      chk("c17_pc",    pc,                  32'h200);
      chk("c17_valid", {31'd0, inst_valid}, 32'd0);
      chk("c17_req",   {31'd0, ibus_req},   32'd0);
      tick(); // c18
      chk("c18_addr",  ibus_addr,           32'h200);
      tick(); // c19
      chk("c19_ipc",   inst_pc,             32'h200);

      // mret beats branch
      mret_req = 1'b1; mepc = 32'h400;
      branch_taken = 1'b1; branch_target = 32'h500;
      tick(); // c20
      mret_req = 1'b0; branch_taken = 1'b0;
      chk("c20_pc",    pc,                  32'h400);
      tick(); // c21
      chk("c21_addr",  ibus_addr,           32'h400);

      // pc wrap at the top of the address space
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      tick(); // c22
      branch_taken = 1'b0;
      chk("c22_pc",    pc,                  32'hFFFF_FFFC);
      tick(); // c23
      chk("c23_addr",  ibus_addr,           32'hFFFF_FFFC);
      tick(); // c24
      chk("c24_pc",    pc,                  32'h0);
      chk("c24_addr",  ibus_addr,           32'h0);
      chk("c24_ipc",   inst_pc,             32'hFFFF_FFFC);
      chk("c24_inst",  inst,                32'h0FFF_FFFC);

      // misaligned branch target
      branch_taken = 1'b1; branch_target = 32'h102;
      tick(); // c25
      branch_taken = 1'b0; ack_en = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("c25_pc",    pc,                        32'h102);
      chk("c25_valid", {31'd0, inst_valid},       32'd1);
      chk("c25_inst",  inst,                      32'h13);
      chk("c25_ipc",   inst_pc,                   32'h102);
      chk("c25_mis",   {31'd0, fetch_misaligned}, 32'd1);
      chk("c25_req",   {31'd0, ibus_req},         32'd0);
      tick(); // c26
      chk("c26_req",   {31'd0, ibus_req},         32'd0);
      chk("c26_valid", {31'd0, inst_valid},       32'd0);
      tick(); // c27
      chk("c27_req",   {31'd0, ibus_req},         32'd0);
`else
      chk("c25_pc",    pc,                        32'h100);
      chk("c25_valid", {31'd0, inst_valid},       32'd0);
      chk("c25_mis",   {31'd0, fetch_misaligned}, 32'd0);
      tick(); // c26
      chk("c26_req",   {31'd0, ibus_req},         32'd1);
      chk("c26_addr",  ibus_addr,                 32'h100);
      tick(); // c27
      chk("c27_req",   {31'd0, ibus_req},         32'd1);
      chk("c27_addr",  ibus_addr,                 32'h100);
`endif

      // asynchronous reset abandons any outstanding request
      rst_n = 1'b0;
      #1;
      chk("arst_req",   {31'd0, ibus_req},   32'd0);
      chk("arst_pc",    pc,                  32'h0);
      chk("arst_valid", {31'd0, inst_valid}, 32'd0);
      tick(); // c28
      rst_n = 1'b1; ack_en = 1'b1;
      tick(); // c29
      chk("c29_req",  {31'd0, ibus_req},   32'd1);
      chk("c29_addr", ibus_addr,           32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 stall  in  1  downstream not accepting inst this cycle.
REQ-005 branch_taken  in  1  execute-stage redirect request.
REQ-006 branch_target  in  32  redirect address for branch_taken.
REQ-007 trap_req  in  1  trap redirect request.
REQ-008 trap_vector  in  32  redirect address for trap_req.
REQ-009 mret_req  in  1  trap-return redirect request.
REQ-010 mepc  in  32  redirect address for mret_req.
REQ-011 ibus_req  out  1  instruction-bus request.
REQ-012 ibus_addr  out  32  instruction-bus word address.
REQ-013 ibus_ack  in  1  bus completes the request; ibus_rdata valid this cycle.
REQ-014 ibus_rdata  in  32  fetched instruction word.
REQ-015 inst_valid  out  1  inst/inst_pc hold a valid instruction.
REQ-016 inst  out  32  head instruction.
REQ-017 inst_pc  out  32  address of head instruction.
REQ-018 pc  out  32  fetch pointer: next address to request.
REQ-019 fetch_misaligned  out  1  head entry is a misaligned-target marker.

Function
REQ-020 The block SHALL hold a 2-entry in-order instruction buffer; head consumed in any cycle with inst_valid=1 and stall=0.
REQ-021 FSM states SHALL be IDLE (no request), REQ (request outstanding, data kept), FLUSH (request outstanding, data discarded).
REQ-022 IDLE->REQ SHALL occur, with ibus_req=1 and ibus_addr=pc the same cycle, when buffer occupancy after this cycle's consume is below 2 and no redirect is active.
REQ-023 While ibus_req=1 without ibus_ack, ibus_addr SHALL stay constant and ibus_req SHALL stay high.
REQ-024 On ibus_ack in REQ without redirect: {ibus_rdata, pc} SHALL be written to the buffer, pc SHALL advance by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), and the next request SHALL issue back-to-back if REQ-022 space holds, else IDLE.
REQ-025 Ack-to-inst_valid latency SHALL be one cycle when the buffer was empty.
REQ-026 Redirect priority SHALL be trap_req > mret_req > branch_taken; redirect SHALL be honoured regardless of stall.
REQ-027 On redirect: pc<=selected target, buffer emptied (inst_valid=0 next cycle), next state FLUSH if ibus_req=1 and ibus_ack=0, else IDLE.
REQ-028 In FLUSH, ibus_ack SHALL discard ibus_rdata and go IDLE; a new redirect in FLUSH SHALL update pc and stay FLUSH.
REQ-029 Earliest request to a redirect target SHALL be the cycle after the redirect.
REQ-030 Simultaneous consume and ack SHALL be legal and leave occupancy unchanged.

Reset
REQ-031 While rst_n=0: state IDLE, pc=RESET_ADDR, buffer empty, ibus_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_misaligned=0.
REQ-032 First request SHALL issue in the first clock edge cycle after rst_n rises; reset mid-request SHALL abandon it without waiting for ack.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHECK_EN defined: redirect target with [1:0]!=0 SHALL not be fetched; a single buffer entry {inst=32'h0000_0013, inst_pc=target, fetch_misaligned=1} SHALL be presented and no further requests issue until the next redirect.
REQ-034 Macro undefined: target[1:0] SHALL be forced to 2'b00 and fetch_misaligned tied to 0.

Structure
REQ-035 FSM state enum, NOP instruction constant and buffer-entry struct SHALL live in package lexington; words typed rv32::word.
REQ-036 The buffer SHALL be sub-module fetch_buf (2-entry FIFO, push/pop/flush, count).

Verification
REQ-037 Reset release, ibus_ack every cycle, stall=0 -> requests to 0x0,0x4,0x8 on consecutive cycles; inst_valid from cycle 2 with inst_pc 0x0,0x4,0x8.
REQ-038 stall=1 held 5 cycles with acks available -> exactly 2 buffered, ibus_req low thereafter, inst/inst_pc stable; release drains in order.
REQ-039 branch_taken to 0x100 while request to 0x10 awaits ack 3 cycles -> addr 0x10 held, its data dropped, next request 0x100, no inst_pc=0x10 seen.
REQ-040 trap_req (vector 0x200) and branch_taken (0x300) same cycle -> pc=0x200, next fetch 0x200.
REQ-041 pc=0xFFFF_FFFC fetch acked -> pc=0x0; with FETCH_MISALIGN_CHECK_EN, branch to 0x102 -> fetch_misaligned=1, inst=0x13, inst_pc=0x102, ibus_req=0.
